// File: rtl/mac_seq.sv
// Pipelined signed multiply-accumulate engine: LEN-term dot product over valid/ready streams.
// Optional saturating arithmetic and sticky ovf port when MAC_SAT_EN is defined.
module mac_seq #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 26,
  parameter int LEN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] acc
`ifdef MAC_SAT_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FLUSH,
    DONE
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [2*IN_W-1:0] r_prod;
  logic                    r_prod_vld;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_in_rdy;
  logic                    r_out_vld;

  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic                    w_last;
  logic signed [2*IN_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0]        w_acc_nxt;

  assign w_in_xfer  = in_vld & r_in_rdy;
  assign w_out_xfer = r_out_vld & out_rdy;
  assign w_last     = (r_cnt == CW'(LEN - 1));
  assign w_prod     = $signed(in1) * $signed(in2);
  assign w_prod_ext = ACC_W'(r_prod);

`ifdef MAC_SAT_EN
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;

  // One guard bit: top two bits disagree exactly on signed overflow.
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_sat = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_sat) begin
      w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !clr_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == DONE && w_out_xfer) begin
      r_ovf <= 1'b0;
    end else if (r_prod_vld && w_sat) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_acc_nxt = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || !clr_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_in_rdy   <= 1'b1;
      r_out_vld  <= 1'b0;
    end else begin
      r_prod_vld <= w_in_xfer;
      if (w_in_xfer) begin
        r_prod <= w_prod;
      end
      if (r_prod_vld) begin
        r_acc <= w_acc_nxt;
      end
      unique case (r_state)
        IDLE, ACC: begin
          if (w_in_xfer) begin
            if (w_last) begin
              r_state  <= FLUSH;
              r_cnt    <= '0;
              r_in_rdy <= 1'b0;
            end else begin
              r_state <= ACC;
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        FLUSH: begin
          r_state   <= DONE;
          r_out_vld <= 1'b1;
        end
        DONE: begin
          if (w_out_xfer) begin
            r_state   <= IDLE;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_acc     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_rdy  = r_in_rdy;
  assign out_vld = r_out_vld;
  assign acc     = r_acc;

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: three instances (LEN=4/ACC_W=26, LEN=4/ACC_W=16, LEN=1).
// Build with MAC_SAT_EN defined to exercise saturation on the 16-bit instance.
module tb_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_n;

  logic        a_vld, a_rdy, a_ov, a_ordy;
  logic [7:0]  a_i1, a_i2;
  logic [25:0] a_acc;
  logic        b_vld, b_rdy, b_ov, b_ordy;
  logic [7:0]  b_i1, b_i2;
  logic [15:0] b_acc;
  logic        c_vld, c_rdy, c_ov, c_ordy;
  logic [7:0]  c_i1, c_i2;
  logic [25:0] c_acc;
`ifdef MAC_SAT_EN
  logic a_ovf, b_ovf, c_ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int q[3][$];

  always #5 clk = ~clk;

  mac_seq #(.IN_W(8), .ACC_W(26), .LEN(4)) ua (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n),
    .in_vld(a_vld), .in_rdy(a_rdy), .in1(a_i1), .in2(a_i2),
    .out_vld(a_ov), .out_rdy(a_ordy), .acc(a_acc)
`ifdef MAC_SAT_EN
    , .ovf(a_ovf)
`endif
  );

  mac_seq #(.IN_W(8), .ACC_W(16), .LEN(4)) ub (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n),
    .in_vld(b_vld), .in_rdy(b_rdy), .in1(b_i1), .in2(b_i2),
    .out_vld(b_ov), .out_rdy(b_ordy), .acc(b_acc)
`ifdef MAC_SAT_EN
    , .ovf(b_ovf)
`endif
  );

  mac_seq #(.IN_W(8), .ACC_W(26), .LEN(1)) uc (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n),
    .in_vld(c_vld), .in_rdy(c_rdy), .in1(c_i1), .in2(c_i2),
    .out_vld(c_ov), .out_rdy(c_ordy), .acc(c_acc)
`ifdef MAC_SAT_EN
    , .ovf(c_ovf)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int val(input int d);
    case (d)
      0:       return int'($signed(a_acc));
      1:       return int'($signed(b_acc));
      default: return int'($signed(c_acc));
    endcase
  endfunction

  function automatic bit rdy(input int d);
    case (d)
      0:       return a_rdy;
      1:       return b_rdy;
      default: return c_rdy;
    endcase
  endfunction

  function automatic bit ov(input int d);
    case (d)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  task automatic set(input int d, input bit v, input int x, input int y);
    case (d)
      0: begin a_vld = v; a_i1 = 8'(x); a_i2 = 8'(y); end
      1: begin b_vld = v; b_i1 = 8'(x); b_i2 = 8'(y); end
      default: begin c_vld = v; c_i1 = 8'(x); c_i2 = 8'(y); end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int d, input int x, input int y);
    int n = 0;
    set(d, 1'b1, x, y);
    @(negedge clk);
    while (!rdy(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(d)) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: dut %0d in_rdy stuck at 0", d);
    end
    @(posedge clk);
    #1;
    set(d, 1'b0, 0, 0);
  endtask

  task automatic wait_vld(input int d);
    int n = 0;
    @(negedge clk);
    while (!ov(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ov(d)) begin
      n_chk++;
      n_fail++;
      $display("FAIL vld_timeout: dut %0d out_vld never rose", d);
    end
  endtask

  task automatic wait_empty(input int d);
    int n = 0;
    while (q[d].size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk($sformatf("dut%0d_drained", d), q[d].size(), 0);
  endtask

  task automatic mon(input int d);
    if (q[d].size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d_result: unexpected result %0d", d, val(d));
    end else begin
      chk($sformatf("dut%0d_result", d), val(d), q[d].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (a_ov && a_ordy) mon(0);
    if (b_ov && b_ordy) mon(1);
    if (c_ov && c_ordy) mon(2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr_n = 1'b1;
    set(0, 0, 0, 0);
    set(1, 0, 0, 0);
    set(2, 0, 0, 0);
    a_ordy = 1'b1;
    b_ordy = 1'b1;
    c_ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc", val(0), 0);
    chk("rst_out_vld", int'(a_ov), 0);
    chk("rst_in_rdy", int'(a_rdy), 1);
    @(posedge clk);
    #1;

    // 4 x (3,5) with latency check
    q[0].push_back(60);
    repeat (4) send(0, 3, 5);
    @(negedge clk);
    chk("lat_edge1_vld", int'(a_ov), 0);
    @(negedge clk);
    chk("lat_edge2_vld", int'(a_ov), 1);
    @(posedge clk);
    #1;
    chk("acc_cleared_after_xfer", val(0), 0);

    q[0].push_back(-65024);
    repeat (4) send(0, -128, 127);
    q[0].push_back(65536);
    repeat (4) send(0, -128, -128);
    wait_empty(0);

    // backpressure in DONE
    a_ordy = 1'b0;
    q[0].push_back(60);
    q[0].push_back(4);
    repeat (4) send(0, 3, 5);
    set(0, 1'b1, 1, 1);
    wait_vld(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_rdy", int'(a_rdy), 0);
      chk("bp_acc_stable", val(0), 60);
      @(negedge clk);
    end
    @(posedge clk);
    #1 a_ordy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_rdy", int'(a_rdy), 1);
    @(posedge clk);
    #1;
    repeat (3) send(0, 1, 1);
    wait_empty(0);

    // clear after 2 of 4 terms; the pair offered during clear is dropped
    send(0, 3, 5);
    send(0, 3, 5);
    set(0, 1'b1, 9, 9);
    clr_n = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
    set(0, 1'b0, 0, 0);
    @(negedge clk);
    chk("clr_acc", val(0), 0);
    chk("clr_out_vld", int'(a_ov), 0);
    chk("clr_in_rdy", int'(a_rdy), 1);
    @(posedge clk);
    #1;
    q[0].push_back(16);
    repeat (4) send(0, 2, 2);
    wait_empty(0);

    // same with reset
    send(0, 3, 5);
    send(0, 3, 5);
    set(0, 1'b1, 9, 9);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set(0, 1'b0, 0, 0);
    @(negedge clk);
    chk("rst2_acc", val(0), 0);
    chk("rst2_out_vld", int'(a_ov), 0);
    chk("rst2_in_rdy", int'(a_rdy), 1);
    @(posedge clk);
    #1;
    q[0].push_back(16);
    repeat (4) send(0, 2, 2);
    wait_empty(0);

    // 16-bit accumulator overflow
`ifdef MAC_SAT_EN
    q[1].push_back(32767);
    chk("ovf_reset", int'(b_ovf), 0);
`else
    q[1].push_back(0);
`endif
    repeat (4) send(1, -128, -128);
`ifdef MAC_SAT_EN
    wait_vld(1);
    chk("ovf_set", int'(b_ovf), 1);
    @(negedge clk);
    chk("ovf_cleared", int'(b_ovf), 0);
    @(posedge clk);
    #1;
`endif
    wait_empty(1);

    // LEN=1
    q[2].push_back(-63);
    send(2, 7, -9);
    @(negedge clk);
    chk("len1_edge1_vld", int'(c_ov), 0);
    @(negedge clk);
    chk("len1_edge2_vld", int'(c_ov), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      int v, x, y;
      v = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 15)) - 8;
      y = int'($urandom_range(0, 15)) - 8;
      set(2, v[0], x, y);
      @(negedge clk);
      if (c_vld && c_rdy) q[2].push_back(x * y);
      @(posedge clk);
      #1;
    end
    set(2, 1'b0, 0, 0);
    wait_empty(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
